// File: rtl/cdc_channel_scheduler_pkg.sv
// Shared types and helpers for the CDC channel scheduler.
package cdc_sched_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Tag field width: enough bits to name every source, never zero.
  function automatic int tag_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cdc_channel_scheduler_if.sv
// Bundle between the producers and the scheduler / crossing.
//
// Handshake: the channel is a constant-handshake crossing with no ready.
// Producers pulse i_src_update[k] for one cycle while i_src_data holds the
// new value for source k. The scheduler drives o_chan_data = {seq, tag,
// payload} and keeps it frozen for HOLD_CYCLES clocks; a toggle of seq
// marks a new word for the destination. o_grant pulses for the first hold
// cycle of each word, and o_busy is high for the whole hold.
interface cdc_channel_scheduler_if
  import cdc_sched_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int PAYLOAD_W = 10
);

  localparam int TAG_W = tag_width(NUM_SRC);
  localparam int CW    = 1 + TAG_W + PAYLOAD_W;

  logic                           i_enable;
  logic [NUM_SRC*PAYLOAD_W-1:0]   i_src_data;
  logic [NUM_SRC-1:0]             i_src_update;
  logic [CW-1:0]                  o_chan_data;
  logic [NUM_SRC-1:0]             o_grant;
  logic                           o_busy;

  // Producer side.
  modport master (
    output i_enable, i_src_data, i_src_update,
    input  o_chan_data, o_grant, o_busy
  );

  // Scheduler side.
  modport slave (
    input  i_enable, i_src_data, i_src_update,
    output o_chan_data, o_grant, o_busy
  );

endinterface

// File: rtl/cdc_channel_scheduler_rr_picker.sv
// Combinational round-robin picker: first set request above the last
// grant, wrapping modulo N.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [IW-1:0] o_winner,
  output logic          o_valid
);

  logic [IW-1:0] w_idx;

  // Scan last+1 .. last+N (mod N) and keep the first requester found.
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_idx    = '0;
    for (int off = 1; off <= N; off++) begin
      w_idx = IW'((int'(i_last) + off) % N);
      if (!o_valid && i_req[w_idx]) begin
        o_valid  = 1'b1;
        o_winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/cdc_channel_scheduler.sv
// Source-domain scheduler that time-shares one constant-handshake crossing
// among NUM_SRC producers: dirty tracking, round-robin grant, fixed-length
// hold of each tagged word, seq toggle per word, and periodic refresh.
module cdc_channel_scheduler
  import cdc_sched_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int PAYLOAD_W      = 10,
  parameter int HOLD_CYCLES    = 8,
  parameter int REFRESH_CYCLES = 1024
) (
  input  logic   i_clk,
  input  logic   rst,
  cdc_channel_scheduler_if.slave bus,
  output state_t o_dbg_state
);

  localparam int TAG_W = tag_width(NUM_SRC);
  localparam int CW    = 1 + TAG_W + PAYLOAD_W;
  localparam int HCW   = $clog2(HOLD_CYCLES + 1);
  localparam int RCW   = (REFRESH_CYCLES == 0) ? 1 : $clog2(REFRESH_CYCLES + 1);

  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);
  // With refresh disabled the counter parks at zero and never matches.
  localparam logic [RCW-1:0] REF_LAST  =
    (REFRESH_CYCLES == 0) ? '0 : RCW'(REFRESH_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [HCW-1:0]       r_hold_cnt;
  logic [HCW-1:0]       w_hold_cnt_next;
  logic [TAG_W-1:0]     r_rr;
  logic [NUM_SRC-1:0]   r_dirty;
  logic [NUM_SRC-1:0]   w_dirty_next;
  logic [RCW-1:0]       r_ref_cnt;
  logic [CW-1:0]        r_chan;
  logic [NUM_SRC-1:0]   r_grant;

  logic [TAG_W-1:0]     w_winner;
  logic                 w_any;
  logic                 w_do_grant;
  logic                 w_refresh;
  logic [NUM_SRC-1:0]   w_win_onehot;
  logic [PAYLOAD_W-1:0] w_payload;

  rr_picker #(
    .N  (NUM_SRC),
    .IW (TAG_W)
  ) u_picker (
    .i_req    (r_dirty),
    .i_last   (r_rr),
    .o_winner (w_winner),
    .o_valid  (w_any)
  );

  assign w_win_onehot = NUM_SRC'(1) << w_winner;
  assign w_payload    = bus.i_src_data[int'(w_winner)*PAYLOAD_W +: PAYLOAD_W];
  assign w_refresh    = (REFRESH_CYCLES != 0) && (r_ref_cnt == REF_LAST);

  // Next state and hold counter; a grant may happen from IDLE or straight
  // out of an expiring HOLD so back-to-back words have no bubble.
  always_comb begin
    w_state_next    = r_state;
    w_hold_cnt_next = r_hold_cnt;
    w_do_grant      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_enable && w_any) begin
          w_do_grant      = 1'b1;
          w_state_next    = HOLD;
          w_hold_cnt_next = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (r_hold_cnt != '0) begin
          w_hold_cnt_next = r_hold_cnt - HCW'(1);
        end else if (bus.i_enable && w_any) begin
          w_do_grant      = 1'b1;
          w_hold_cnt_next = HOLD_LOAD;
        end else begin
          w_state_next    = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Dirty set wins over grant clear so a coincident update is not lost.
  always_comb begin
    w_dirty_next = r_dirty;
    if (w_do_grant) begin
      w_dirty_next = w_dirty_next & ~w_win_onehot;
    end
    w_dirty_next = w_dirty_next | bus.i_src_update;
    if (w_refresh) begin
      w_dirty_next = '1;
    end
  end

  // FSM, dirty, pointer and the frozen channel word.
  always_ff @(posedge i_clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_rr       <= TAG_W'(NUM_SRC - 1);
      r_dirty    <= '1;
      r_chan     <= '0;
      r_grant    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_cnt_next;
      r_dirty    <= w_dirty_next;
      r_grant    <= w_do_grant ? w_win_onehot : '0;
      if (w_do_grant) begin
        r_chan <= {~r_chan[CW-1], w_winner, w_payload};
        r_rr   <= w_winner;
      end
    end
  end

  // Free-running refresh period counter.
  always_ff @(posedge i_clk) begin
    if (!rst) begin
      r_ref_cnt <= '0;
    end else if (REFRESH_CYCLES == 0) begin
      r_ref_cnt <= '0;
    end else if (r_ref_cnt == REF_LAST) begin
      r_ref_cnt <= '0;
    end else begin
      r_ref_cnt <= r_ref_cnt + RCW'(1);
    end
  end

  assign bus.o_chan_data = r_chan;
  assign bus.o_grant     = r_grant;
  assign bus.o_busy      = (r_state == HOLD);
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_cdc_channel_scheduler.sv
// Directed bench: dut A (refresh off) for sweep/grant/arbitration cases,
// dut B (refresh every 64) for the refresh and mid-hold reset cases.
module tb_cdc_channel_scheduler;
  import cdc_sched_pkg::*;

  localparam int NS = 4;
  localparam int PW = 10;
  localparam int CW = 13;

  logic   clk = 1'b0;
  logic   rst;
  state_t a_state;
  state_t b_state;
  int     n_run  = 0;
  int     n_fail = 0;
  logic   exp_seq;

  logic [PW-1:0] sweep_data [NS] = '{10'h011, 10'h022, 10'h033, 10'h044};
  logic [PW-1:0] b_data     [NS] = '{10'h201, 10'h202, 10'h203, 10'h204};

  cdc_channel_scheduler_if #(.NUM_SRC(NS), .PAYLOAD_W(PW)) bus_a ();
  cdc_channel_scheduler_if #(.NUM_SRC(NS), .PAYLOAD_W(PW)) bus_b ();

  cdc_channel_scheduler #(
    .NUM_SRC(NS), .PAYLOAD_W(PW), .HOLD_CYCLES(8), .REFRESH_CYCLES(0)
  ) u_dut_a (
    .i_clk(clk), .rst(rst), .bus(bus_a.slave), .o_dbg_state(a_state)
  );

  cdc_channel_scheduler #(
    .NUM_SRC(NS), .PAYLOAD_W(PW), .HOLD_CYCLES(8), .REFRESH_CYCLES(64)
  ) u_dut_b (
    .i_clk(clk), .rst(rst), .bus(bus_b.slave), .o_dbg_state(b_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a_data(input int k, input logic [PW-1:0] v);
    bus_a.i_src_data[k*PW +: PW] = v;
  endtask

  task automatic pulse_a_update(input logic [NS-1:0] m);
    bus_a.i_src_update = m;
    tick();
    bus_a.i_src_update = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus_a.i_enable = 1'b1;
    bus_a.i_src_update = '0;
    bus_b.i_enable = 1'b1;
    bus_b.i_src_update = '0;
    for (int k = 0; k < NS; k++) begin
      set_a_data(k, sweep_data[k]);
      bus_b.i_src_data[k*PW +: PW] = b_data[k];
    end
    repeat (3) tick();
    n_run++; if (bus_a.o_chan_data !== 13'h0) begin n_fail++; $display("FAIL reset_chan: got %h want 0", bus_a.o_chan_data); end
    n_run++; if (bus_a.o_grant !== 4'b0) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", bus_a.o_grant); end
    n_run++; if (bus_a.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus_a.o_busy); end
    n_run++; if (a_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", a_state); end
    n_run++; if (bus_b.o_chan_data !== 13'h0) begin n_fail++; $display("FAIL reset_chan_b: got %h want 0", bus_b.o_chan_data); end
    rst = 1'b1;
    exp_seq = 1'b0;
  endtask

  task automatic test_sweep();
    logic [CW-1:0] ew;
    for (int k = 0; k < NS; k++) begin
      tick();
      exp_seq = ~exp_seq;
      ew = {exp_seq, 2'(k), sweep_data[k]};
      n_run++; if (bus_a.o_grant !== 4'(1 << k)) begin n_fail++; $display("FAIL sweep_grant k=%0d: got %b want %b", k, bus_a.o_grant, 4'(1 << k)); end
      n_run++; if (bus_a.o_chan_data !== ew) begin n_fail++; $display("FAIL sweep_chan k=%0d: got %h want %h", k, bus_a.o_chan_data, ew); end
      for (int j = 1; j < 8; j++) begin
        tick();
        n_run++; if ({bus_a.o_busy, bus_a.o_grant, bus_a.o_chan_data} !== {1'b1, 4'b0, ew}) begin
          n_fail++; $display("FAIL sweep_hold k=%0d j=%0d: got busy=%b grant=%b chan=%h want busy=1 grant=0000 chan=%h",
                              k, j, bus_a.o_busy, bus_a.o_grant, bus_a.o_chan_data, ew);
        end
      end
    end
    tick();
    n_run++; if (bus_a.o_busy !== 1'b0) begin n_fail++; $display("FAIL sweep_end_busy: got %b want 0", bus_a.o_busy); end
    n_run++; if (bus_a.o_chan_data !== {1'b0, 2'd3, 10'h044}) begin n_fail++; $display("FAIL sweep_end_chan: got %h want %h", bus_a.o_chan_data, {1'b0, 2'd3, 10'h044}); end
  endtask

  task automatic test_single();
    logic [CW-1:0] ew;
    set_a_data(2, 10'h155);
    pulse_a_update(4'b0100);
    n_run++; if (bus_a.o_busy !== 1'b0) begin n_fail++; $display("FAIL single_pre_busy: got %b want 0", bus_a.o_busy); end
    tick();
    exp_seq = ~exp_seq;
    ew = {exp_seq, 2'd2, 10'h155};
    n_run++; if (bus_a.o_grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", bus_a.o_grant); end
    n_run++; if (bus_a.o_chan_data !== ew) begin n_fail++; $display("FAIL single_chan: got %h want %h", bus_a.o_chan_data, ew); end
    for (int j = 1; j < 8; j++) begin
      tick();
      n_run++; if ({bus_a.o_busy, bus_a.o_grant, bus_a.o_chan_data} !== {1'b1, 4'b0, ew}) begin
        n_fail++; $display("FAIL single_hold j=%0d: got busy=%b grant=%b chan=%h want chan=%h", j, bus_a.o_busy, bus_a.o_grant, bus_a.o_chan_data, ew);
      end
    end
    tick();
    n_run++; if (bus_a.o_busy !== 1'b0) begin n_fail++; $display("FAIL single_end_busy: got %b want 0", bus_a.o_busy); end
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] ew;
    set_a_data(1, 10'h0AA);
    pulse_a_update(4'b0010);
    tick();
    exp_seq = ~exp_seq;
    n_run++; if (bus_a.o_grant !== 4'b0010) begin n_fail++; $display("FAIL b2b_prime_grant: got %b want 0010", bus_a.o_grant); end
    repeat (7) tick();
    tick();
    n_run++; if (bus_a.o_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_prime_idle: got %b want 0", bus_a.o_busy); end
    set_a_data(1, 10'h1B1);
    set_a_data(3, 10'h2C3);
    pulse_a_update(4'b1010);
    tick();
    exp_seq = ~exp_seq;
    ew = {exp_seq, 2'd3, 10'h2C3};
    n_run++; if (bus_a.o_grant !== 4'b1000) begin n_fail++; $display("FAIL b2b_first_grant: got %b want 1000", bus_a.o_grant); end
    n_run++; if (bus_a.o_chan_data !== ew) begin n_fail++; $display("FAIL b2b_first_chan: got %h want %h", bus_a.o_chan_data, ew); end
    repeat (7) tick();
    n_run++; if ({bus_a.o_busy, bus_a.o_chan_data} !== {1'b1, ew}) begin n_fail++; $display("FAIL b2b_first_hold: got busy=%b chan=%h want chan=%h", bus_a.o_busy, bus_a.o_chan_data, ew); end
    tick();
    exp_seq = ~exp_seq;
    ew = {exp_seq, 2'd1, 10'h1B1};
    n_run++; if (bus_a.o_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_no_bubble: got busy=%b want 1", bus_a.o_busy); end
    n_run++; if (bus_a.o_grant !== 4'b0010) begin n_fail++; $display("FAIL b2b_second_grant: got %b want 0010", bus_a.o_grant); end
    n_run++; if (bus_a.o_chan_data !== ew) begin n_fail++; $display("FAIL b2b_second_chan: got %h want %h", bus_a.o_chan_data, ew); end
    repeat (7) tick();
    tick();
    n_run++; if (bus_a.o_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end_busy: got %b want 0", bus_a.o_busy); end
  endtask

  task automatic test_same_edge();
    logic [CW-1:0] ew;
    set_a_data(0, 10'h0A5);
    bus_a.i_src_update = 4'b0001;
    tick();
    tick();
    bus_a.i_src_update = '0;
    set_a_data(0, 10'h05A);
    exp_seq = ~exp_seq;
    ew = {exp_seq, 2'd0, 10'h0A5};
    n_run++; if (bus_a.o_grant !== 4'b0001) begin n_fail++; $display("FAIL same_first_grant: got %b want 0001", bus_a.o_grant); end
    n_run++; if (bus_a.o_chan_data !== ew) begin n_fail++; $display("FAIL same_first_chan: got %h want %h", bus_a.o_chan_data, ew); end
    repeat (7) tick();
    n_run++; if (bus_a.o_chan_data !== ew) begin n_fail++; $display("FAIL same_first_hold: got %h want %h", bus_a.o_chan_data, ew); end
    tick();
    exp_seq = ~exp_seq;
    ew = {exp_seq, 2'd0, 10'h05A};
    n_run++; if (bus_a.o_grant !== 4'b0001) begin n_fail++; $display("FAIL same_resend_grant: got %b want 0001", bus_a.o_grant); end
    n_run++; if (bus_a.o_chan_data !== ew) begin n_fail++; $display("FAIL same_resend_chan: got %h want %h", bus_a.o_chan_data, ew); end
    repeat (7) tick();
    tick();
    n_run++; if (bus_a.o_busy !== 1'b0) begin n_fail++; $display("FAIL same_end_busy: got %b want 0", bus_a.o_busy); end
  endtask

  task automatic test_enable();
    logic [CW-1:0] ew;
    set_a_data(2, 10'h1C3);
    pulse_a_update(4'b0100);
    tick();
    exp_seq = ~exp_seq;
    ew = {exp_seq, 2'd2, 10'h1C3};
    n_run++; if (bus_a.o_grant !== 4'b0100) begin n_fail++; $display("FAIL en_grant: got %b want 0100", bus_a.o_grant); end
    bus_a.i_enable = 1'b0;
    set_a_data(1, 10'h0F0);
    set_a_data(3, 10'h30F);
    pulse_a_update(4'b1010);
    repeat (6) tick();
    n_run++; if (bus_a.o_busy !== 1'b1) begin n_fail++; $display("FAIL en_hold_completes: got busy=%b want 1", bus_a.o_busy); end
    tick();
    n_run++; if ({bus_a.o_busy, bus_a.o_chan_data} !== {1'b0, ew}) begin n_fail++; $display("FAIL en_idle: got busy=%b chan=%h want busy=0 chan=%h", bus_a.o_busy, bus_a.o_chan_data, ew); end
    repeat (4) tick();
    n_run++; if ({bus_a.o_busy, bus_a.o_grant} !== 5'b0) begin n_fail++; $display("FAIL en_blocked: got busy=%b grant=%b want 0 0000", bus_a.o_busy, bus_a.o_grant); end
    bus_a.i_enable = 1'b1;
    tick();
    exp_seq = ~exp_seq;
    ew = {exp_seq, 2'd3, 10'h30F};
    n_run++; if (bus_a.o_grant !== 4'b1000) begin n_fail++; $display("FAIL en_resume_grant3: got %b want 1000", bus_a.o_grant); end
    n_run++; if (bus_a.o_chan_data !== ew) begin n_fail++; $display("FAIL en_resume_chan3: got %h want %h", bus_a.o_chan_data, ew); end
    repeat (7) tick();
    tick();
    exp_seq = ~exp_seq;
    ew = {exp_seq, 2'd1, 10'h0F0};
    n_run++; if (bus_a.o_grant !== 4'b0010) begin n_fail++; $display("FAIL en_resume_grant1: got %b want 0010", bus_a.o_grant); end
    n_run++; if (bus_a.o_chan_data !== ew) begin n_fail++; $display("FAIL en_resume_chan1: got %h want %h", bus_a.o_chan_data, ew); end
    repeat (7) tick();
    tick();
    n_run++; if (bus_a.o_busy !== 1'b0) begin n_fail++; $display("FAIL en_end_busy: got %b want 0", bus_a.o_busy); end
  endtask

  task automatic test_refresh();
    logic          b_seq;
    int            ph;
    logic [NS-1:0] eg;
    logic [CW-1:0] ew;
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    b_seq = 1'b0;
    // Sweep at edges 1,9,17,25 then again 64 edges later, twice.
    for (int e = 1; e <= 140; e++) begin
      tick();
      ph = (e - 1) % 64;
      eg = (ph < 32 && ph % 8 == 0) ? 4'(1 << (ph / 8)) : 4'b0;
      n_run++; if (bus_b.o_grant !== eg) begin n_fail++; $display("FAIL refresh_grant e=%0d: got %b want %b", e, bus_b.o_grant, eg); end
      n_run++; if (bus_b.o_busy !== (ph < 32)) begin n_fail++; $display("FAIL refresh_busy e=%0d: got %b want %b", e, bus_b.o_busy, (ph < 32)); end
      if (eg != 4'b0) begin
        b_seq = ~b_seq;
        ew = {b_seq, 2'(ph / 8), b_data[ph / 8]};
        n_run++; if (bus_b.o_chan_data !== ew) begin n_fail++; $display("FAIL refresh_chan e=%0d: got %h want %h", e, bus_b.o_chan_data, ew); end
      end
    end
    rst = 1'b0;
    tick();
    n_run++; if (bus_b.o_chan_data !== 13'h0) begin n_fail++; $display("FAIL midhold_rst_chan: got %h want 0", bus_b.o_chan_data); end
    n_run++; if ({bus_b.o_busy, bus_b.o_grant} !== 5'b0) begin n_fail++; $display("FAIL midhold_rst_busy: got busy=%b grant=%b want 0 0000", bus_b.o_busy, bus_b.o_grant); end
    n_run++; if (b_state !== IDLE) begin n_fail++; $display("FAIL midhold_rst_state: got %0d want IDLE", b_state); end
    rst = 1'b1;
    b_seq = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      tick();
      ph = e - 1;
      eg = (ph % 8 == 0) ? 4'(1 << (ph / 8)) : 4'b0;
      n_run++; if (bus_b.o_grant !== eg) begin n_fail++; $display("FAIL restart_grant e=%0d: got %b want %b", e, bus_b.o_grant, eg); end
      if (eg != 4'b0) begin
        b_seq = ~b_seq;
        ew = {b_seq, 2'(ph / 8), b_data[ph / 8]};
        n_run++; if (bus_b.o_chan_data !== ew) begin n_fail++; $display("FAIL restart_chan e=%0d: got %h want %h", e, bus_b.o_chan_data, ew); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_single();
    test_back_to_back();
    test_same_edge();
    test_enable();
    test_refresh();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
